// File: rtl/stage_reg_ctl_if.sv
// Bundle of the stage register's control, payload and status signals.
// master: the surrounding pipeline that drives requests/payload and observes the stage.
// slave: the stage register itself.
interface stage_reg_ctl_if #(
  parameter int DATA_W    = 256,
  parameter int NUM_FLUSH = 2,
  parameter int CNT_W     = 32
);
  logic [NUM_FLUSH-1:0] flush_req;
  logic [NUM_FLUSH-1:0] flush_ok;
  logic                 bubble_in;
  logic                 hold;
  logic                 valid_in;
  logic [DATA_W-1:0]    data_in;
  logic                 valid_out;
  logic [DATA_W-1:0]    data_out;
  logic [NUM_FLUSH-1:0] flush_pend;
  logic [CNT_W-1:0]     cnt_hold;
  logic [CNT_W-1:0]     cnt_bubble;
  logic [CNT_W-1:0]     cnt_flush;

  modport master (
    output flush_req, flush_ok, bubble_in, hold, valid_in, data_in,
    input  valid_out, data_out, flush_pend, cnt_hold, cnt_bubble, cnt_flush
  );

  modport slave (
    input  flush_req, flush_ok, bubble_in, hold, valid_in, data_in,
    output valid_out, data_out, flush_pend, cnt_hold, cnt_bubble, cnt_flush
  );
endinterface

// File: rtl/stage_reg_ctl.sv
// Pipeline stage register with gated/deferred flushes, bubble insertion and hold.
// Latency: 1 cycle data_in -> data_out; all outputs registered, no comb input->output path.
// Backpressure: hold keeps contents; flush > bubble > hold > load. Perf counters under STAGE_REG_PERF_EN.
module stage_reg_ctl #(
  parameter int DATA_W    = 256,
  parameter int NUM_FLUSH = 2,
  parameter int CNT_W     = 32
) (
  input  logic           clk,
  input  logic           reset,
  stage_reg_ctl_if.slave bus
);

  logic [NUM_FLUSH-1:0] fire;
  logic                 any_fire;

  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q,  data_d;
  logic [NUM_FLUSH-1:0] flush_pend_q, flush_pend_d;

  // A source fires when a new or deferred request meets an open gate; an open
  // gate always retires the pending flag, otherwise a request parks in it.
  always_comb begin
    fire         = (bus.flush_req | flush_pend_q) & bus.flush_ok;
    any_fire     = |fire;
    flush_pend_d = ~bus.flush_ok & (bus.flush_req | flush_pend_q);
  end

  // Register next-state: flush, then bubble (all-zero NOP), then hold, then load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (any_fire || bus.bubble_in) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (!bus.hold) begin
      valid_d = bus.valid_in;
      data_d  = bus.data_in;
    end
  end

  // Stage payload and deferred-flush flags; synchronous reset drops everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      flush_pend_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.data_out   = data_q;
  assign bus.flush_pend = flush_pend_q;

`ifdef STAGE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             do_flush, do_bubble, do_hold;
  logic [CNT_W-1:0] cnt_hold_q,   cnt_hold_d;
  logic [CNT_W-1:0] cnt_bubble_q, cnt_bubble_d;
  logic [CNT_W-1:0] cnt_flush_q,  cnt_flush_d;

  // Classify the cycle by the priority level that updates the register and
  // bump the matching counter, saturating at all-ones.
  always_comb begin
    do_flush     = any_fire;
    do_bubble    = !any_fire && bus.bubble_in;
    do_hold      = !any_fire && !bus.bubble_in && bus.hold;
    cnt_hold_d   = cnt_hold_q;
    cnt_bubble_d = cnt_bubble_q;
    cnt_flush_d  = cnt_flush_q;
    if (do_hold && (cnt_hold_q != '1))
      cnt_hold_d = cnt_hold_q + CNT_ONE;
    if (do_bubble && (cnt_bubble_q != '1))
      cnt_bubble_d = cnt_bubble_q + CNT_ONE;
    if (do_flush && (cnt_flush_q != '1))
      cnt_flush_d = cnt_flush_q + CNT_ONE;
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_hold_q   <= '0;
      cnt_bubble_q <= '0;
      cnt_flush_q  <= '0;
    end else begin
      cnt_hold_q   <= cnt_hold_d;
      cnt_bubble_q <= cnt_bubble_d;
      cnt_flush_q  <= cnt_flush_d;
    end
  end

  assign bus.cnt_hold   = cnt_hold_q;
  assign bus.cnt_bubble = cnt_bubble_q;
  assign bus.cnt_flush  = cnt_flush_q;
`else
  assign bus.cnt_hold   = '0;
  assign bus.cnt_bubble = '0;
  assign bus.cnt_flush  = '0;
`endif

endmodule

// File: doc/stage_reg_ctl.md
# stage_reg_ctl

Parametrised pipeline stage register for the in-order pipeline, used between any two stages (E→M, M→W, and so on). It holds one stage payload and applies, in fixed priority, reset, gated flushes, bubble insertion, hold and load. Flush requests that arrive while their gating bus is busy are latched and applied once the bus frees, so a flush is never lost. An optional performance block counts hold, bubble and flush cycles.

## Interface
Parameters:
- `DATA_W`, default 256: payload width in bits.
- `NUM_FLUSH`, default 2: number of independent flush sources, each with its own gate.
- `CNT_W`, default 32: width of each perf counter (used only with the perf macro).

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `flush_req`  in  NUM_FLUSH: flush request per source; level-sampled each cycle.
- `flush_ok`  in  NUM_FLUSH: gate per source; 1 means the associated bus is not busy.
- `bubble_in`  in  1: upstream stall; load a bubble instead of `data_in`.
- `hold`  in  1: downstream stall; keep the current contents.
- `valid_in`  in  1: upstream payload valid.
- `data_in`  in  DATA_W: upstream payload.
- `valid_out`  out  1: registered valid.
- `data_out`  out  DATA_W: registered payload.
- `flush_pend`  out  NUM_FLUSH: per-source deferred-flush flags.
- `cnt_hold`, `cnt_bubble`, `cnt_flush`  out  CNT_W each: perf counters.

## Operation
- Per source i: `fire[i] = (flush_req[i] | flush_pend[i]) & flush_ok[i]`.
- `flush_pend[i]` update, evaluated in this order:
  - cleared on reset;
  - else cleared when `flush_ok[i]` is 1;
  - else set when `flush_req[i]` is 1;
  - else held.
- Register update priority, highest first:
  1. `reset`: `valid_out=0`, `data_out=0`.
  2. Any `fire[i]`: `valid_out=0`, `data_out=0`.
  3. `bubble_in`: `valid_out=0`, `data_out=0`.
  4. `hold`: `valid_out` and `data_out` unchanged.
  5. Otherwise: `valid_out<=valid_in`, `data_out<=data_in`.
- A bubble is always all-zero payload with valid 0. Downstream logic relies on zero meaning NOP.
- Flush overrides hold: a stalled stage that receives a firing flush is cleared.
- While a pending flush is waiting for its gate, normal bubble, hold and load behaviour continues. The pending flush clears the register on the cycle its gate opens, including any payload loaded in the meantime.
- Repeated requests while pending collapse into one flush. Sources are independent.

## Timing
- Reset values: `valid_out=0`, `data_out=0`, `flush_pend=0`, all counters 0.
- Latency is 1 cycle, `data_in` to `data_out`. No combinational path from any input to any output.
- Flush with `flush_ok=1` in cycle t: register is cleared at edge t+1 and no pending flag is set.
- Flush with `flush_ok=0` in cycle t: `flush_pend[i]=1` after edge t+1. In the first cycle t' with `flush_ok[i]=1`, the register is cleared at edge t'+1 and `flush_pend[i]` becomes 0 at the same edge. `flush_req` does not need to be held.
- Simultaneous `flush_req[i]` and `flush_ok[i]` while already pending: a single flush, and pend clears.
- Reset asserted mid-pending discards all pending flushes.
- `bubble_in` and `hold` together: bubble wins and the register is cleared.

## Configuration
- Macro `STAGE_REG_PERF_EN`.
- Defined:
  - `cnt_hold` increments on cycles where priority 4 applies;
  - `cnt_bubble` increments on priority 3;
  - `cnt_flush` increments on priority 2;
  - all three saturate at all-ones and clear on reset.
- Undefined: the counters are tied to 0 and no counter flops are generated. All other behaviour is identical.

## Test plan
- Load, then hold: `valid_in=1`, `data_in=0xA5` → `data_out=0xA5`, `valid_out=1` next cycle. Then `hold=1` for 3 cycles with `data_in=0x3C` → output stays `0xA5`.
- Bubble beats hold: `bubble_in=1`, `hold=1`, `data_in=0x11` → `data_out=0`, `valid_out=0` next cycle. With perf enabled, `cnt_bubble=1` and `cnt_hold=0`.
- Deferred flush: `data_out=0x77`. Pulse `flush_req[0]` for 1 cycle with `flush_ok[0]=0` → `flush_pend[0]=1`, and loads continue (`data_in=0x88` appears on the output). Raise `flush_ok[0]` → output 0 the next cycle and `flush_pend[0]=0`.
- Flush beats hold: `hold=1`, `flush_req[1]=1`, `flush_ok[1]=1` → output cleared in 1 cycle and `flush_pend[1]` stays 0.
- Reset mid-pending: `flush_pend=2'b11`, then `reset=1` for 1 cycle → `flush_pend=0`. Later `flush_ok=2'b11` with no request → no flush, and the loaded data passes through.
- Saturation (`STAGE_REG_PERF_EN`, `CNT_W=4`): 20 hold cycles → `cnt_hold=15`.
